// File: rtl/gray_async_fifo_pkg.sv
// Shared default parameters and Gray-code conversion helpers for gray_async_fifo.
package gray_async_fifo_pkg;

   localparam int DEF_DATA_WIDTH  = 64;
   localparam int DEF_ADDR_WIDTH  = 9;
   localparam int DEF_SYNC_STAGES = 2;

   // Widest pointer is ADDR_WIDTH(16)+1; narrower pointers are zero-extended by callers.
   localparam int PTR_MAX_W = 17;
   typedef logic [PTR_MAX_W-1:0] ptr_max_t;

   function automatic ptr_max_t bin2gray(input ptr_max_t bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic ptr_max_t gray2bin(input ptr_max_t gray);
      ptr_max_t bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser used for every Gray pointer crossing and for the read-domain reset.
// arst_n_i clears asynchronously, srst_n_i clears on the clock; tie the unused one high.
module gray_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             arst_n_i,
   input  logic             srst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   // NOTE: non-blocking assignments let each stage sample its predecessor's old value.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      end else if (!srst_n_i) begin
         for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gray_async_fifo.sv
// Dual-clock FIFO: inferred RAM, binary pointers with registered Gray copies crossing domains.
// Define GRAY_ASYNC_FIFO_LEVEL_EN to add the registered wr_level/rd_level occupancy outputs.
module gray_async_fifo
   import gray_async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
) (
   input  logic                  clk_wr,
   input  logic                  clk_rd,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] d_wr,
   output logic                  full,
   output logic                  wr_afull,
   output logic                  wr_ovf,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] d_rd,
   output logic                  rd_valid,
   output logic                  empty
`ifdef GRAY_ASYNC_FIFO_LEVEL_EN
   ,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic [ADDR_WIDTH:0]   rd_level
`endif
);

   localparam int PTR_W = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

   typedef logic [PTR_W-1:0] ptr_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   ptr_t wptr_q, wptr_d, wgray_q, wgray_d, rgray_wsync, rbin_wsync;
   logic full_q, full_d, afull_q, afull_d, ovf_q, ovf_d, wr_fire;

   ptr_t rptr_q, rptr_d, rgray_q, rgray_d, wgray_rsync;
   logic empty_q, empty_d, rd_valid_q, rd_fire, rd_rst_n;
   logic [DATA_WIDTH-1:0] d_rd_q;

   // ---------------- write domain ----------------
   // NOTE: every variable is assigned on every pass through this block, so no latch can form.
   always_comb begin
      wr_fire    = wr_en && !full_q;
      wptr_d     = wptr_q + PTR_W'(wr_fire);
      wgray_d    = PTR_W'(bin2gray(PTR_MAX_W'(wptr_d)));
      rbin_wsync = PTR_W'(gray2bin(PTR_MAX_W'(rgray_wsync)));
      // Full when the next write pointer has lapped the read pointer by exactly one depth.
      full_d     = (wgray_d == {~rgray_wsync[PTR_W-1 -: 2], rgray_wsync[PTR_W-3:0]});
      afull_d    = ((wptr_d - rbin_wsync) >= AFULL_LVL);
      ovf_d      = wr_en && full_q;
   end

   always_ff @(posedge clk_wr) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         wgray_q <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         wgray_q <= wgray_d;
         full_q  <= full_d;
         afull_q <= afull_d;
         ovf_q   <= ovf_d;
      end
   end

   // NOTE: the storage array is deliberately not reset so it maps onto dual-clock block RAM.
   always_ff @(posedge clk_wr) begin
      if (rst_n && wr_fire) mem[wptr_q[ADDR_WIDTH-1:0]] <= d_wr;
   end

   gray_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rgray_sync (
      .clk_i    (clk_wr),
      .arst_n_i (1'b1),
      .srst_n_i (rst_n),
      .d_i      (rgray_q),
      .q_o      (rgray_wsync)
   );

   // ---------------- read domain ----------------
   // Reset enters the read domain immediately and leaves it SYNC_STAGES clk_rd edges later.
   gray_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rd_rst_sync (
      .clk_i    (clk_rd),
      .arst_n_i (rst_n),
      .srst_n_i (1'b1),
      .d_i      (1'b1),
      .q_o      (rd_rst_n)
   );

   gray_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wgray_sync (
      .clk_i    (clk_rd),
      .arst_n_i (rd_rst_n),
      .srst_n_i (1'b1),
      .d_i      (wgray_q),
      .q_o      (wgray_rsync)
   );

   always_comb begin
      rd_fire = rd_en && !empty_q;
      rptr_d  = rptr_q + PTR_W'(rd_fire);
      rgray_d = PTR_W'(bin2gray(PTR_MAX_W'(rptr_d)));
      empty_d = (rgray_d == wgray_rsync);
   end

   always_ff @(posedge clk_rd or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         rptr_q     <= '0;
         rgray_q    <= '0;
         empty_q    <= 1'b1;
         rd_valid_q <= 1'b0;
         d_rd_q     <= '0;
      end else begin
         rptr_q     <= rptr_d;
         rgray_q    <= rgray_d;
         empty_q    <= empty_d;
         rd_valid_q <= rd_fire;
         if (rd_fire) d_rd_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
      end
   end

`ifdef GRAY_ASYNC_FIFO_LEVEL_EN
   ptr_t wr_level_q, rd_level_q, wbin_rsync;

   assign wbin_rsync = PTR_W'(gray2bin(PTR_MAX_W'(wgray_rsync)));

   always_ff @(posedge clk_wr) begin
      if (!rst_n) wr_level_q <= '0;
      else        wr_level_q <= wptr_d - rbin_wsync;
   end

   always_ff @(posedge clk_rd or negedge rd_rst_n) begin
      if (!rd_rst_n) rd_level_q <= '0;
      else           rd_level_q <= wbin_rsync - rptr_d;
   end

   assign wr_level = wr_level_q;
   assign rd_level = rd_level_q;
`else
   // Without the level option only the write side converts the far Gray pointer to binary.
`endif

   assign full     = full_q;
   assign wr_afull = afull_q;
   assign wr_ovf   = ovf_q;
   assign d_rd     = d_rd_q;
   assign rd_valid = rd_valid_q;
   assign empty    = empty_q;

endmodule

// File: tb/tb_gray_async_fifo.sv
// Directed bench for gray_async_fifo: 16x16 FIFO, clk_wr 6 ns, clk_rd 10 ns (edges never coincide).
module tb_gray_async_fifo;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int SS = 2;

   logic clk_wr = 1'b0;
   logic clk_rd = 1'b0;
   logic rst_n  = 1'b0;
   logic wr_en  = 1'b0;
   logic rd_en  = 1'b0;
   logic [DW-1:0] d_wr = '0;
   logic [DW-1:0] d_rd;
   logic full, wr_afull, wr_ovf, rd_valid, empty;
`ifdef GRAY_ASYNC_FIFO_LEVEL_EN
   logic [AW:0] wr_level, rd_level;
`endif

   int checks   = 0;
   int errors   = 0;
   int rd_edges = 0;
   int e0, sent, got;
   logic acc;

   always #3 clk_wr = ~clk_wr;
   initial begin
      #1;
      forever #5 clk_rd = ~clk_rd;
   end

   always @(posedge clk_rd) rd_edges <= rd_edges + 1;

   gray_async_fifo #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .SYNC_STAGES (SS)
   ) dut (
      .clk_wr   (clk_wr),
      .clk_rd   (clk_rd),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .d_wr     (d_wr),
      .full     (full),
      .wr_afull (wr_afull),
      .wr_ovf   (wr_ovf),
      .rd_en    (rd_en),
      .d_rd     (d_rd),
      .rd_valid (rd_valid),
      .empty    (empty)
`ifdef GRAY_ASYNC_FIFO_LEVEL_EN
      ,
      .wr_level (wr_level),
      .rd_level (rd_level)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_wr(input int n);
      repeat (n) @(posedge clk_wr);
      #1;
   endtask

   task automatic wait_rd(input int n);
      repeat (n) @(posedge clk_rd);
      #1;
   endtask

   // Caller is aligned 1 ns after a clk_wr edge.
   task automatic wr_word(input logic [DW-1:0] data);
      wr_en = 1'b1;
      d_wr  = data;
      @(posedge clk_wr);
      #1;
      wr_en = 1'b0;
   endtask

   // Caller is aligned 1 ns after a clk_rd edge.
   task automatic rd_word();
      rd_en = 1'b1;
      @(posedge clk_rd);
      #1;
      rd_en = 1'b0;
   endtask

   initial begin
      // Reset state
      wait_wr(4);
      check("rst_full", 32'(full), 0);
      check("rst_afull", 32'(wr_afull), 0);
      check("rst_ovf", 32'(wr_ovf), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_d_rd", 32'(d_rd), 0);
      rst_n = 1'b1;
      wait_rd(4);
      wait_wr(1);

      // Fill to full with reads off
      for (int i = 1; i <= 16; i++) begin
         wr_word(16'(i));
         check($sformatf("fill_afull_%0d", i), 32'(wr_afull), (i >= 12) ? 1 : 0);
         check($sformatf("fill_full_%0d", i), 32'(full), (i == 16) ? 1 : 0);
         check($sformatf("fill_ovf_%0d", i), 32'(wr_ovf), 0);
      end
      wr_word(16'h0011);
      check("ovf_pulse", 32'(wr_ovf), 1);
      check("ovf_full", 32'(full), 1);
      wait_wr(1);
      check("ovf_clear", 32'(wr_ovf), 0);

      // Drain all 16 words in order
      wait_rd(4);
      check("pre_read_empty", 32'(empty), 0);
      for (int i = 1; i <= 16; i++) begin
         rd_word();
         check($sformatf("drain_valid_%0d", i), 32'(rd_valid), 1);
         check($sformatf("drain_data_%0d", i), 32'(d_rd), 32'(i));
         check($sformatf("drain_empty_%0d", i), 32'(empty), (i == 16) ? 1 : 0);
      end
      rd_word();
      check("underflow_valid", 32'(rd_valid), 0);
      check("underflow_hold", 32'(d_rd), 32'h0010);
      wait_wr(6);
      check("drained_full", 32'(full), 0);
      check("drained_afull", 32'(wr_afull), 0);

      // First-word latency with rd_en held high
      wait_rd(1);
      rd_en = 1'b1;
      wait_wr(1);
      wr_en = 1'b1;
      d_wr  = 16'hBEEF;
      @(posedge clk_wr);
      e0 = rd_edges;
      #1 wr_en = 1'b0;
      for (int n = 0; n < 12 && !rd_valid; n++) begin
         @(posedge clk_rd);
         #1;
      end
      check("lat_valid", 32'(rd_valid), 1);
      check("lat_edges", 32'(rd_edges - e0), 4);
      check("lat_data", 32'(d_rd), 32'hBEEF);
      wait_rd(1);
      check("lat_single", 32'(rd_valid), 0);
      rd_en = 1'b0;

      // Concurrent streaming with random enables
      sent = 0;
      got  = 0;
      wait_wr(1);
      fork
         begin
            for (int c = 0; c < 20000 && sent < 1000; c++) begin
               wr_en = ($urandom_range(0, 3) != 0);
               d_wr  = 16'(32'h0100 + sent);
               acc   = wr_en && !full;
               @(posedge clk_wr);
               #1;
               if (acc) sent++;
            end
            wr_en = 1'b0;
         end
         begin
            @(posedge clk_rd);
            #1;
            for (int c = 0; c < 20000 && got < 1000; c++) begin
               rd_en = ($urandom_range(0, 2) != 0);
               @(posedge clk_rd);
               #1;
               if (rd_valid) begin
                  check("stream_data", 32'(d_rd), 32'(16'(32'h0100 + got)));
                  got++;
               end
            end
            rd_en = 1'b0;
         end
      join
      check("stream_sent", sent, 1000);
      check("stream_count", got, 1000);
      wait_rd(4);
      check("stream_empty", 32'(empty), 1);
      wait_wr(4);
      check("stream_full", 32'(full), 0);

      // Reset during occupancy discards contents
      for (int i = 0; i < 8; i++) wr_word(16'(32'h0050 + i));
      wait_rd(5);
      check("pre_rst_empty", 32'(empty), 0);
      wait_wr(1);
      rst_n = 1'b0;
      wait_wr(2);
      check("mid_rst_full", 32'(full), 0);
      check("mid_rst_afull", 32'(wr_afull), 0);
      check("mid_rst_empty", 32'(empty), 1);
      check("mid_rst_d_rd", 32'(d_rd), 0);
      rst_n = 1'b1;
      wait_wr(2);
      wr_word(16'h00AA);
      wait_rd(1);
      rd_en = 1'b1;
      for (int n = 0; n < 12 && !rd_valid; n++) begin
         @(posedge clk_rd);
         #1;
      end
      check("post_rst_valid", 32'(rd_valid), 1);
      check("post_rst_data", 32'(d_rd), 32'h00AA);
      wait_rd(1);
      check("post_rst_single", 32'(rd_valid), 0);
      check("post_rst_empty", 32'(empty), 1);
      rd_en = 1'b0;

`ifdef GRAY_ASYNC_FIFO_LEVEL_EN
      // Occupancy outputs
      wait_wr(1);
      for (int i = 0; i < 5; i++) wr_word(16'(32'h0060 + i));
      wait_rd(6);
      check("level_wr_5", 32'(wr_level), 5);
      check("level_rd_5", 32'(rd_level), 5);
      rd_word();
      rd_word();
      wait_rd(6);
      check("level_wr_3", 32'(wr_level), 3);
      check("level_rd_3", 32'(rd_level), 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
